// File: rtl/eeprom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_pkg
//  Description : Shared defaults and FSM state encoding for the EEPROM
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package eeprom_pkg;

    localparam int         c_ADDR_W_DEF   = 11;
    localparam int         c_DATA_W_DEF   = 8;
    localparam logic [7:0] c_INIT_VAL_DEF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_ADDR      = 3'd2,
        ST_WDATA     = 3'd3,
        ST_RDATA     = 3'd4,
        ST_WAIT_STOP = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eeprom_mem.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_mem
//  Description : 2^ADDR_W x DATA_W storage, one synchronous write port, one
//                asynchronous read port, every word loaded on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_mem
    import eeprom_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W_DEF,
    parameter int                DATA_W   = c_DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(c_INIT_VAL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= INIT_VAL;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/eeprom_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_rsp
//  Description : Two-wire serial EEPROM responder (w_r, address, data frames,
//                LSB first). Optional write protect via EEPROM_RSP_WP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_rsp
    import eeprom_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W_DEF,
    parameter int                DATA_W   = c_DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(c_INIT_VAL_DEF)
) (
    input  logic sclk,
    input  logic rst,
`ifdef EEPROM_RSP_WP_EN
    input  logic wp,
`endif
    input  logic scl,
    inout  wire  sda,
    output logic busy,
    output logic wr_done,
    output logic rd_done,
    output logic err
);

    localparam logic [3:0] c_ADDR_LAST = 4'(ADDR_W - 1);
    localparam logic [3:0] c_DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] c_DATA_END  = 4'(DATA_W);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic              r_w_r, w_w_r_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_sda_oe, w_sda_oe_nxt;
    logic              r_sda_out, w_sda_out_nxt;
    logic              r_commit, w_commit_nxt;
    logic              r_rd_done, w_rd_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_scl, r_sda;

    logic              w_sda_in;
    logic              w_scl_rise, w_scl_fall;
    logic              w_start, w_stop;
    logic              w_in_frame;
    logic              w_wp;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rdata;

`ifdef EEPROM_RSP_WP_EN
    assign w_wp = wp;
`else
    assign w_wp = 1'b0;
`endif

    assign w_sda_in   = sda;
    assign w_scl_rise = scl & ~r_scl;
    assign w_scl_fall = ~scl & r_scl;
    // Our own read bits must never be mistaken for bus conditions
    assign w_start    = r_scl & scl & r_sda & ~w_sda_in & ~r_sda_oe;
    assign w_stop     = r_scl & scl & ~r_sda & w_sda_in & ~r_sda_oe;
    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_WAIT_STOP);

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_w_r     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_sda_oe  <= 1'b0;
            r_sda_out <= 1'b0;
            r_commit  <= 1'b0;
            r_rd_done <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_scl     <= scl;
            r_sda     <= w_sda_in;
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_w_r     <= w_w_r_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_sda_out <= w_sda_out_nxt;
            r_commit  <= w_commit_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_w_r_nxt     = r_w_r;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_sda_oe_nxt  = r_sda_oe;
        w_sda_out_nxt = r_sda_out;
        w_commit_nxt  = 1'b0;
        w_rd_done_nxt = 1'b0;
        w_err_nxt     = 1'b0;

        if (w_start) begin
            w_err_nxt     = w_in_frame;
            w_state_nxt   = ST_CMD;
            w_bit_cnt_nxt = '0;
            w_addr_nxt    = '0;
            w_data_nxt    = '0;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            w_err_nxt     = w_in_frame;
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_scl_rise) begin
                        w_w_r_nxt     = w_sda_in;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_addr_nxt = {w_sda_in, r_addr[ADDR_W-1:1]};
                        if (r_bit_cnt == c_ADDR_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = r_w_r ? ST_RDATA : ST_WDATA;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_data_nxt = {w_sda_in, r_data[DATA_W-1:1]};
                        if (r_bit_cnt == c_DATA_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_commit_nxt  = 1'b1;
                            w_state_nxt   = ST_WAIT_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    // Word is latched on the first fall, then shifted out LSB first
                    if (w_scl_fall) begin
                        if (r_bit_cnt == c_DATA_END) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_rd_done_nxt = 1'b1;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_WAIT_STOP;
                        end else if (r_bit_cnt == 4'd0) begin
                            w_sda_oe_nxt  = 1'b1;
                            w_sda_out_nxt = w_rdata[0];
                            w_data_nxt    = {1'b0, w_rdata[DATA_W-1:1]};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end else begin
                            w_sda_out_nxt = r_data[0];
                            w_data_nxt    = {1'b0, r_data[DATA_W-1:1]};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Commit happens in the cycle after the last data sample
    assign w_mem_we = r_commit & ~w_wp;

    eeprom_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_VAL (INIT_VAL)
    ) u_mem (
        .clk     (sclk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (r_addr),
        .i_wdata (r_data),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    assign sda     = r_sda_oe ? r_sda_out : 1'bz;
    assign busy    = (r_state != ST_IDLE);
    assign wr_done = w_mem_we;
    assign rd_done = r_rd_done;
    assign err     = r_err | (r_commit & w_wp);

endmodule
`default_nettype wire
